// File: rtl/rom_loader.sv
// rom_loader: turns a framed UART byte stream into 32-bit little-endian ROM writes.
// Define LOADER_CHECKSUM_EN to require and verify a trailing modulo-256 checksum byte.
module rom_loader #(
    parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
    parameter int unsigned ROM_WORDS   = 4096,
    parameter logic [7:0]  SYNC_BYTE   = 8'hA5,
    parameter int unsigned TIMEOUT_CYC = 1_000_000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [7:0]  rx_data_i,
    input  logic        rx_valid_i,
    output logic        erase_en_o,
    output logic        wr_en_o,
    output logic [31:0] wr_addr_o,
    output logic [31:0] data_o,
    output logic        cpu_hold_o,
    output logic        busy_o,
    output logic        done_o,
    output logic        err_o,
    output logic [1:0]  err_code_o
);
    localparam int unsigned TW = $clog2(TIMEOUT_CYC + 1);

    typedef enum logic [2:0] {IDLE, LEN0, LEN1, DATA, CSUM, DONE, ERR} state_t;

    state_t        state_q;
    logic [15:0]   len_q;
    logic [15:0]   idx_q;
    logic [1:0]    byte_cnt_q;
    logic [23:0]   lanes_q;
    logic [TW-1:0] tmo_q;
    logic [1:0]    pend_code_q;
    logic          erase_q;
    logic          wr_en_q;
    logic          done_q;
    logic          hold_q;
    logic          err_q;
    logic [1:0]    err_code_q;
    logic [31:0]   addr_q;
    logic [31:0]   data_q;
`ifdef LOADER_CHECKSUM_EN
    logic [7:0]    csum_q;
`endif

    logic [15:0] len_d;
    logic        len_bad;
    logic        tmo_hit;

    assign len_d   = {rx_data_i, len_q[7:0]};
    assign len_bad = (len_d == 16'd0) || (32'(len_d) > ROM_WORDS);
    assign tmo_hit = (32'(tmo_q) == TIMEOUT_CYC);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            len_q       <= '0;
            idx_q       <= '0;
            byte_cnt_q  <= '0;
            lanes_q     <= '0;
            tmo_q       <= '0;
            pend_code_q <= '0;
            erase_q     <= 1'b0;
            wr_en_q     <= 1'b0;
            done_q      <= 1'b0;
            hold_q      <= 1'b0;
            err_q       <= 1'b0;
            err_code_q  <= '0;
            addr_q      <= '0;
            data_q      <= '0;
`ifdef LOADER_CHECKSUM_EN
            csum_q      <= '0;
`endif
        end else begin
            // NOTE: non-blocking throughout, so every branch sees the pre-edge state and later defaults never race.
            erase_q <= 1'b0;
            wr_en_q <= 1'b0;
            done_q  <= 1'b0;

            // Any received byte restarts the inter-byte watchdog, even on the limit cycle.
            if (state_q inside {LEN0, LEN1, DATA, CSUM}) begin
                if (rx_valid_i) begin
                    tmo_q <= '0;
                end else if (tmo_hit) begin
                    state_q     <= ERR;
                    pend_code_q <= 2'b10;
                end else begin
                    tmo_q <= tmo_q + 1'b1;
                end
            end

            case (state_q)
                IDLE: begin
                    if (rx_valid_i && rx_data_i == SYNC_BYTE) begin
                        state_q    <= LEN0;
                        erase_q    <= 1'b1;
                        hold_q     <= 1'b1;
                        err_q      <= 1'b0;
                        err_code_q <= 2'b00;
                        idx_q      <= '0;
                        byte_cnt_q <= '0;
                        tmo_q      <= '0;
`ifdef LOADER_CHECKSUM_EN
                        csum_q     <= '0;
`endif
                    end
                end
                LEN0: begin
                    if (rx_valid_i) begin
                        len_q[7:0] <= rx_data_i;
                        state_q    <= LEN1;
                    end
                end
                LEN1: begin
                    if (rx_valid_i) begin
                        len_q <= len_d;
                        if (len_bad) begin
                            state_q     <= ERR;
                            pend_code_q <= 2'b01;
                        end else begin
                            state_q <= DATA;
                        end
                    end
                end
                DATA: begin
                    if (rx_valid_i) begin
                        byte_cnt_q <= byte_cnt_q + 2'd1;
`ifdef LOADER_CHECKSUM_EN
                        csum_q     <= csum_q + rx_data_i;
`endif
                        case (byte_cnt_q)
                            2'd0: lanes_q[7:0]   <= rx_data_i;
                            2'd1: lanes_q[15:8]  <= rx_data_i;
                            2'd2: lanes_q[23:16] <= rx_data_i;
                            default: begin
                                wr_en_q <= 1'b1;
                                data_q  <= {rx_data_i, lanes_q};
                                addr_q  <= BASE_ADDR + {14'd0, idx_q, 2'b00};
                                idx_q   <= idx_q + 16'd1;
                                if (idx_q == len_q - 16'd1) begin
`ifdef LOADER_CHECKSUM_EN
                                    state_q <= CSUM;
`else
                                    state_q <= DONE;
`endif
                                end
                            end
                        endcase
                    end
                end
                CSUM: begin
`ifdef LOADER_CHECKSUM_EN
                    if (rx_valid_i) begin
                        if (rx_data_i == csum_q) begin
                            state_q <= DONE;
                        end else begin
                            state_q     <= ERR;
                            pend_code_q <= 2'b11;
                        end
                    end
`else
                    state_q <= IDLE;
                    hold_q  <= 1'b0;
`endif
                end
                DONE: begin
                    done_q  <= 1'b1;
                    hold_q  <= 1'b0;
                    state_q <= IDLE;
                end
                ERR: begin
                    err_q      <= 1'b1;
                    err_code_q <= pend_code_q;
                    hold_q     <= 1'b0;
                    state_q    <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                    hold_q  <= 1'b0;
                end
            endcase
        end
    end

    assign erase_en_o = erase_q;
    assign wr_en_o    = wr_en_q;
    assign wr_addr_o  = addr_q;
    assign data_o     = data_q;
    assign cpu_hold_o = hold_q;
    assign busy_o     = (state_q != IDLE);
    assign done_o     = done_q;
    assign err_o      = err_q;
    assign err_code_o = err_code_q;

endmodule

// File: tb/tb_rom_loader.sv
// Self-checking bench for rom_loader: length table, hand-written corner sequences, random frames.
// Follows LOADER_CHECKSUM_EN so the frame format matches the build under test.
module tb_rom_loader;
    localparam int unsigned T_CYC = 40;
    localparam logic [31:0] BASE  = 32'h0000_0000;
    localparam int unsigned ROM_W = 4096;
    localparam logic [7:0]  SYNC  = 8'hA5;
`ifdef LOADER_CHECKSUM_EN
    localparam bit CSUM_ON = 1'b1;
`else
    localparam bit CSUM_ON = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [7:0]  rx_data_i = 8'h00;
    logic        rx_valid_i = 1'b0;
    logic        erase_en_o, wr_en_o, cpu_hold_o, busy_o, done_o, err_o;
    logic [31:0] wr_addr_o, data_o;
    logic [1:0]  err_code_o;

    rom_loader #(
        .BASE_ADDR(BASE), .ROM_WORDS(ROM_W), .SYNC_BYTE(SYNC), .TIMEOUT_CYC(T_CYC)
    ) dut (
        .clk(clk), .rst_n(rst_n), .rx_data_i(rx_data_i), .rx_valid_i(rx_valid_i),
        .erase_en_o(erase_en_o), .wr_en_o(wr_en_o), .wr_addr_o(wr_addr_o), .data_o(data_o),
        .cpu_hold_o(cpu_hold_o), .busy_o(busy_o), .done_o(done_o), .err_o(err_o),
        .err_code_o(err_code_o)
    );

    always #5 clk = ~clk;

    int compared = 0;
    int mismatched = 0;

    logic [63:0] wr_log[$];
    int erase_cnt = 0, done_cnt = 0;
    int overlap_cnt = 0, misalign_cnt = 0, hold_busy_cnt = 0, erase_hold_cnt = 0;

    // Passive observer: records every write and pulse, and tracks cycle-level invariants.
    always @(negedge clk) begin
        if (rst_n) begin
            if (wr_en_o) begin
                wr_log.push_back({wr_addr_o, data_o});
                if (wr_addr_o[1:0] != 2'b00) misalign_cnt++;
            end
            if (erase_en_o) erase_cnt++;
            if (erase_en_o && !cpu_hold_o) erase_hold_cnt++;
            if (done_o) done_cnt++;
            if (wr_en_o && done_o) overlap_cnt++;
            if (cpu_hold_o != busy_o) hold_busy_cnt++;
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic int rgap(input int m);
        return int'($urandom_range(m, 0));
    endfunction

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic send_byte(input logic [7:0] b, input int gap);
        rx_data_i  = b;
        rx_valid_i = 1'b1;
        @(negedge clk);
        rx_valid_i = 1'b0;
        rx_data_i  = 8'($urandom);
        idle(gap);
    endtask

    task automatic clear_log();
        wr_log.delete();
        erase_cnt = 0;
        done_cnt  = 0;
    endtask

    // Builds the frame from the word list; the checksum is xor-corrupted by csum_xor.
    task automatic send_frame(input logic [31:0] words[$], input logic [7:0] csum_xor,
                              input int max_gap, output bit bad);
        logic [7:0]  sum;
        logic [7:0]  by;
        logic [15:0] n;
        sum = 8'h00;
        n   = 16'(words.size());
        send_byte(SYNC, rgap(max_gap));
        send_byte(n[7:0], rgap(max_gap));
        send_byte(n[15:8], rgap(max_gap));
        foreach (words[k]) begin
            for (int b = 0; b < 4; b++) begin
                by  = words[k][8*b +: 8];
                sum = sum + by;
                send_byte(by, rgap(max_gap));
            end
        end
        if (CSUM_ON) send_byte(sum ^ csum_xor, 0);
        bad = CSUM_ON && (csum_xor != 8'h00);
    endtask

    // Expected outcome: word k at BASE+4k, one erase, done only when the checksum was good.
    task automatic verify_load(input string name, input logic [31:0] words[$], input bit bad);
        idle(6);
        check({name, " write count"}, 32'(wr_log.size()), 32'(words.size()));
        foreach (words[k]) begin
            if (k < wr_log.size()) begin
                check({name, " addr"}, wr_log[k][63:32], BASE + 32'(4 * k));
                check({name, " data"}, wr_log[k][31:0], words[k]);
            end
        end
        check({name, " erase pulses"}, 32'(erase_cnt), 32'd1);
        check({name, " done pulses"}, 32'(done_cnt), bad ? 32'd0 : 32'd1);
        check({name, " err_o"}, 32'(err_o), bad ? 32'd1 : 32'd0);
        check({name, " err_code"}, 32'(err_code_o), bad ? 32'd3 : 32'd0);
        check({name, " hold/busy released"}, 32'({cpu_hold_o, busy_o}), 32'd0);
    endtask

    typedef struct {
        logic [15:0] len;
        bit          exp_err;
        logic [1:0]  exp_code;
    } len_vec_t;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not reach its summary");
        $fatal(1, "watchdog expired");
    end

    initial begin
        len_vec_t    lv[6];
        logic [31:0] w[$];
        bit          bad;
        int          waited;
        logic [7:0]  sum;
        logic [7:0]  bytes[$];

        lv = '{'{16'h0000, 1'b1, 2'b01}, '{16'h2001, 1'b1, 2'b01}, '{16'h1001, 1'b1, 2'b01},
               '{16'hFFFF, 1'b1, 2'b01}, '{16'h0001, 1'b0, 2'b00}, '{16'h0003, 1'b0, 2'b00}};

        // Reset and idle
        idle(3);
        rst_n = 1'b1;
        idle(10);
        check("reset flags", 32'({erase_en_o, wr_en_o, done_o, cpu_hold_o, busy_o, err_o, err_code_o}), 32'd0);
        check("reset addr", wr_addr_o, 32'd0);
        check("reset data", data_o, 32'd0);

        // Junk bytes then the two-word example frame
        clear_log();
        send_byte(8'h00, 1);
        send_byte(8'h3C, 1);
        check("junk ignored", 32'(busy_o), 32'd0);
        w.delete();
        w.push_back(32'h0000_0013);
        w.push_back(32'h0000_006F);
        send_frame(w, 8'h00, 0, bad);
        verify_load("example", w, bad);

        // Length table
        for (int i = 0; i < 6; i++) begin
            clear_log();
            if (lv[i].exp_err) begin
                send_byte(SYNC, 0);
                send_byte(lv[i].len[7:0], 0);
                send_byte(lv[i].len[15:8], 0);
                idle(4);
                check($sformatf("len %0h err_o", lv[i].len), 32'(err_o), 32'd1);
                check($sformatf("len %0h code", lv[i].len), 32'(err_code_o), 32'(lv[i].exp_code));
                check($sformatf("len %0h no write", lv[i].len), 32'(wr_log.size()), 32'd0);
                check($sformatf("len %0h hold", lv[i].len), 32'(cpu_hold_o), 32'd0);
                check($sformatf("len %0h done", lv[i].len), 32'(done_cnt), 32'd0);
            end else begin
                w.delete();
                repeat (int'(lv[i].len)) w.push_back($urandom);
                send_frame(w, 8'h00, 1, bad);
                verify_load($sformatf("len %0h", lv[i].len), w, bad);
            end
        end

        // Silence mid-word triggers timeout
        clear_log();
        send_byte(SYNC, 0);
        send_byte(8'h01, 0);
        send_byte(8'h00, 0);
        send_byte(8'h11, 0);
        send_byte(8'h22, 0);
        waited = 0;
        while (!err_o && waited < int'(T_CYC) + 10) begin
            @(negedge clk);
            waited++;
        end
        check("timeout err_o", 32'(err_o), 32'd1);
        check("timeout not early", 32'(waited >= int'(T_CYC) - 2), 32'd1);
        check("timeout code", 32'(err_code_o), 32'd2);
        check("timeout no write", 32'(wr_log.size()), 32'd0);
        check("timeout hold", 32'(cpu_hold_o), 32'd0);
        clear_log();
        w.delete();
        w.push_back($urandom);
        w.push_back($urandom);
        send_frame(w, 8'h00, 2, bad);
        verify_load("after timeout", w, bad);

        // Every gap exactly at the limit: the byte wins each time
        clear_log();
        bytes = '{SYNC, 8'h01, 8'h00, 8'h78, 8'h56, 8'h34, 8'h12};
        sum = 8'h78 + 8'h56 + 8'h34 + 8'h12;
        if (CSUM_ON) bytes.push_back(sum);
        foreach (bytes[k]) send_byte(bytes[k], int'(T_CYC));
        w.delete();
        w.push_back(32'h1234_5678);
        verify_load("gap at limit", w, 1'b0);

`ifdef LOADER_CHECKSUM_EN
        // Bad checksum: word still written, error code 11, no done
        clear_log();
        w.delete();
        w.push_back(32'h4433_2211);
        send_frame(w, 8'hAA, 0, bad);
        verify_load("bad csum", w, 1'b1);
`endif

        // Reset during DATA of a maximum-length frame
        clear_log();
        send_byte(SYNC, 0);
        send_byte(8'h00, 0);
        send_byte(8'h10, 0);
        check("max len accepted", 32'({busy_o, err_o}), 32'h2);
        foreach (lv[k]) begin end
        send_byte(8'hDE, 0);
        send_byte(8'hAD, 0);
        send_byte(8'hBE, 0);
        send_byte(8'hEF, 0);
        send_byte(8'h01, 0);
        send_byte(8'h02, 0);
        check("max len first write", 32'(wr_log.size()), 32'd1);
        check("max len first data", (wr_log.size() > 0) ? wr_log[0][31:0] : 32'd0, 32'hEFBE_ADDE);
        #2 rst_n = 1'b0;
        #1;
        check("mid reset flags", 32'({erase_en_o, wr_en_o, done_o, cpu_hold_o, busy_o, err_o, err_code_o}), 32'd0);
        check("mid reset addr", wr_addr_o, 32'd0);
        check("mid reset data", data_o, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        idle(2);
        clear_log();
        w.delete();
        repeat (3) w.push_back($urandom);
        send_frame(w, 8'h00, 1, bad);
        verify_load("after mid reset", w, bad);

        // Randomized frames with junk prefixes and small gaps
        for (int f = 0; f < 20; f++) begin
            logic [7:0] x;
            logic [7:0] j;
            clear_log();
            repeat ($urandom_range(3, 0)) begin
                do j = 8'($urandom); while (j == SYNC);
                send_byte(j, rgap(2));
            end
            w.delete();
            repeat ($urandom_range(6, 1)) w.push_back($urandom);
            x = ($urandom_range(3, 0) == 0) ? 8'($urandom_range(255, 1)) : 8'h00;
            send_frame(w, x, 3, bad);
            verify_load($sformatf("rand%0d", f), w, bad);
        end

        check("write/done overlap", 32'(overlap_cnt), 32'd0);
        check("misaligned addr", 32'(misalign_cnt), 32'd0);
        check("hold vs busy", 32'(hold_busy_cnt), 32'd0);
        check("erase without hold", 32'(erase_hold_cnt), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule
